// File: rtl/eq_band_mixer.sv
// eq_band_mixer: per-band gain with saturation, saturating band sum and a
// master volume stage, for both stereo channels.
// Build option: define EQ_MIX_RAMP_EN to slew-limit the master volume by
// RAMP_STEP per accepted sample. Without it, the volume jumps to pot_vol on
// every accepted sample.
// Handshake: a sample is accepted on every rising edge where in_vld is high.
// There is no backpressure. Three cycles later out_vld pulses for one cycle
// with that sample's result, and aud_out_* hold their value between pulses.
module eq_band_mixer #(
    parameter int NUM_BANDS = 5,
    parameter int DATA_W    = 16,
    parameter int POT_W     = 12,
    parameter int RAMP_STEP = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_vld,
    input  logic [NUM_BANDS*DATA_W-1:0]   band_lft,
    input  logic [NUM_BANDS*DATA_W-1:0]   band_rght,
    input  logic [NUM_BANDS*POT_W-1:0]    pot_band,
    input  logic [POT_W-1:0]              pot_vol,
    input  logic                          clr_clip,
    output logic signed [DATA_W-1:0]      aud_out_lft,
    output logic signed [DATA_W-1:0]      aud_out_rght,
    output logic                          out_vld,
    output logic                          clip_lft,
    output logic                          clip_rght,
    output logic [POT_W-1:0]              vol_cur
);

    // Products keep one extra bit for the zero-extended unsigned pot.
    localparam int PROD_W = DATA_W + POT_W + 1;
    // With at most 8 bands, the sum fits in DATA_W+3 bits.
    localparam int ACC_W  = DATA_W + 3;

    localparam logic signed [PROD_W-1:0] P_MAX = {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] P_MIN = {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0]  A_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  A_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    if (NUM_BANDS < 1 || NUM_BANDS > 8) begin : g_bad_num_bands
        $error("eq_band_mixer: NUM_BANDS must be in 1..8");
    end
    if (RAMP_STEP < 1 || RAMP_STEP >= (1 << POT_W)) begin : g_bad_ramp_step
        $error("eq_band_mixer: RAMP_STEP must be in 1..2^POT_W-1");
    end

    // Band gain: floor(smp * gain / 2^(POT_W-1)), saturated. Returns {sat, value}.
    function automatic logic [DATA_W:0] scale_sat(input logic [DATA_W-1:0] smp,
                                                  input logic [POT_W-1:0]  gain);
        logic signed [PROD_W-1:0] prod;
        logic signed [PROD_W-1:0] shf;
        prod = {{(PROD_W-DATA_W){smp[DATA_W-1]}}, smp} * {{(PROD_W-POT_W){1'b0}}, gain};
        shf  = prod >>> (POT_W - 1);
        if (shf > P_MAX)      scale_sat = {1'b1, P_MAX[DATA_W-1:0]};
        else if (shf < P_MIN) scale_sat = {1'b1, P_MIN[DATA_W-1:0]};
        else                  scale_sat = {1'b0, shf[DATA_W-1:0]};
    endfunction

    // Sum all bands of one channel, then saturate. Returns {sat, value}.
    function automatic logic [DATA_W:0] sum_sat(input logic [NUM_BANDS*DATA_W-1:0] vals);
        logic signed [ACC_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_BANDS; i++) begin
            acc = acc + {{(ACC_W-DATA_W){vals[i*DATA_W+DATA_W-1]}}, vals[i*DATA_W +: DATA_W]};
        end
        if (acc > A_MAX)      sum_sat = {1'b1, A_MAX[DATA_W-1:0]};
        else if (acc < A_MIN) sum_sat = {1'b1, A_MIN[DATA_W-1:0]};
        else                  sum_sat = {1'b0, acc[DATA_W-1:0]};
    endfunction

    // Pipeline state
    logic                         s1_vld_q;
    logic [NUM_BANDS*DATA_W-1:0]  s1_lft_q, s1_rght_q;
    logic [POT_W-1:0]             s1_vol_q;
    logic                         s2_vld_q;
    logic signed [DATA_W-1:0]     s2_lft_q, s2_rght_q;
    logic [POT_W-1:0]             s2_vol_q;
    logic                         out_vld_q;
    logic signed [DATA_W-1:0]     out_lft_q, out_rght_q;
    logic                         clip_lft_q, clip_rght_q;
    logic [POT_W-1:0]             vol_cur_q;

    // Next-state / combinational signals
    logic [NUM_BANDS*DATA_W-1:0]  s1_lft_d, s1_rght_d;
    logic                         sat1_lft, sat1_rght;
    logic signed [DATA_W-1:0]     s2_lft_d, s2_rght_d;
    logic                         sat2_lft, sat2_rght;
    logic signed [PROD_W-1:0]     prod3_lft, prod3_rght;
    logic signed [DATA_W-1:0]     out_lft_d, out_rght_d;
    logic                         clip_lft_d, clip_rght_d;
    logic [POT_W-1:0]             vol_nxt;
    logic                         unused_prod3;

    // S1: scale every band of both channels by its pot and flag any saturation.
    always_comb begin
        logic [DATA_W:0] sc_l;
        logic [DATA_W:0] sc_r;
        s1_lft_d  = '0;
        s1_rght_d = '0;
        sat1_lft  = 1'b0;
        sat1_rght = 1'b0;
        sc_l      = '0;
        sc_r      = '0;
        for (int i = 0; i < NUM_BANDS; i++) begin
            sc_l = scale_sat(band_lft[i*DATA_W +: DATA_W], pot_band[i*POT_W +: POT_W]);
            sc_r = scale_sat(band_rght[i*DATA_W +: DATA_W], pot_band[i*POT_W +: POT_W]);
            s1_lft_d[i*DATA_W +: DATA_W]  = sc_l[DATA_W-1:0];
            s1_rght_d[i*DATA_W +: DATA_W] = sc_r[DATA_W-1:0];
            sat1_lft  = sat1_lft  | sc_l[DATA_W];
            sat1_rght = sat1_rght | sc_r[DATA_W];
        end
    end

`ifdef EQ_MIX_RAMP_EN
    localparam logic [POT_W-1:0] STEP = POT_W'(RAMP_STEP);

    // Volume slew: move toward pot_vol by at most STEP, landing exactly on it.
    always_comb begin
        vol_nxt = vol_cur_q;
        if (pot_vol > vol_cur_q) begin
            vol_nxt = ((pot_vol - vol_cur_q) > STEP) ? (vol_cur_q + STEP) : pot_vol;
        end else if (pot_vol < vol_cur_q) begin
            vol_nxt = ((vol_cur_q - pot_vol) > STEP) ? (vol_cur_q - STEP) : pot_vol;
        end
    end
`else
    // Volume jumps straight to the pot value.
    assign vol_nxt = pot_vol;
`endif

    // S2: saturating band sums.
    always_comb begin
        {sat2_lft, s2_lft_d}   = sum_sat(s1_lft_q);
        {sat2_rght, s2_rght_d} = sum_sat(s1_rght_q);
    end

    // S3: apply the volume that travelled with the sample. Full scale is just
    // below unity, so the floor result always fits in DATA_W.
    always_comb begin
        prod3_lft  = {{(PROD_W-DATA_W){s2_lft_q[DATA_W-1]}}, s2_lft_q} *
                     {{(PROD_W-POT_W){1'b0}}, s2_vol_q};
        prod3_rght = {{(PROD_W-DATA_W){s2_rght_q[DATA_W-1]}}, s2_rght_q} *
                     {{(PROD_W-POT_W){1'b0}}, s2_vol_q};
        out_lft_d  = prod3_lft[POT_W +: DATA_W];
        out_rght_d = prod3_rght[POT_W +: DATA_W];
    end

    assign unused_prod3 = ^{prod3_lft[POT_W-1:0], prod3_lft[PROD_W-1:POT_W+DATA_W],
                            prod3_rght[POT_W-1:0], prod3_rght[PROD_W-1:POT_W+DATA_W]};

    // Sticky clip flags. A new saturation takes priority over a clear in the same cycle.
    always_comb begin
        clip_lft_d  = (clip_lft_q  & ~clr_clip) | (in_vld & sat1_lft)  | (s1_vld_q & sat2_lft);
        clip_rght_d = (clip_rght_q & ~clr_clip) | (in_vld & sat1_rght) | (s1_vld_q & sat2_rght);
    end

    // Pipeline, volume and flag registers. Reset discards every in-flight sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q    <= 1'b0;
            s1_lft_q    <= '0;
            s1_rght_q   <= '0;
            s1_vol_q    <= '0;
            s2_vld_q    <= 1'b0;
            s2_lft_q    <= '0;
            s2_rght_q   <= '0;
            s2_vol_q    <= '0;
            out_vld_q   <= 1'b0;
            out_lft_q   <= '0;
            out_rght_q  <= '0;
            clip_lft_q  <= 1'b0;
            clip_rght_q <= 1'b0;
            vol_cur_q   <= '0;
        end else begin
            s1_vld_q    <= in_vld;
            if (in_vld) begin
                s1_lft_q  <= s1_lft_d;
                s1_rght_q <= s1_rght_d;
                s1_vol_q  <= vol_nxt;
                vol_cur_q <= vol_nxt;
            end
            s2_vld_q    <= s1_vld_q;
            if (s1_vld_q) begin
                s2_lft_q  <= s2_lft_d;
                s2_rght_q <= s2_rght_d;
                s2_vol_q  <= s1_vol_q;
            end
            out_vld_q   <= s2_vld_q;
            if (s2_vld_q) begin
                out_lft_q  <= out_lft_d;
                out_rght_q <= out_rght_d;
            end
            clip_lft_q  <= clip_lft_d;
            clip_rght_q <= clip_rght_d;
        end
    end

    assign aud_out_lft  = out_lft_q;
    assign aud_out_rght = out_rght_q;
    assign out_vld      = out_vld_q;
    assign clip_lft     = clip_lft_q;
    assign clip_rght    = clip_rght_q;
    assign vol_cur      = vol_cur_q;

endmodule

// File: tb/tb_eq_band_mixer.sv
// Directed bench for eq_band_mixer (5 bands, 16-bit data, 12-bit pots).
// Expected values come from the floor/saturation arithmetic of the datapath.
`timescale 1ns/1ps
module tb_eq_band_mixer;
    localparam int NB = 5;
    localparam int DW = 16;
    localparam int PW = 12;
    localparam int RS = 16;
`ifdef EQ_MIX_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif
    localparam int NSETTLE = RAMP ? 260 : 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_vld;
    logic [NB*DW-1:0]      band_lft, band_rght;
    logic [NB*PW-1:0]      pot_band;
    logic [PW-1:0]         pot_vol;
    logic                  clr_clip;
    logic signed [DW-1:0]  aud_l, aud_r;
    logic                  out_vld, clip_l, clip_r;
    logic [PW-1:0]         vol_cur;

    int checks   = 0;
    int failures = 0;

    logic signed [DW-1:0] exp_l_q[$];
    logic signed [DW-1:0] exp_r_q[$];

    eq_band_mixer #(.NUM_BANDS(NB), .DATA_W(DW), .POT_W(PW), .RAMP_STEP(RS)) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld),
        .band_lft(band_lft), .band_rght(band_rght), .pot_band(pot_band),
        .pot_vol(pot_vol), .clr_clip(clr_clip),
        .aud_out_lft(aud_l), .aud_out_rght(aud_r), .out_vld(out_vld),
        .clip_lft(clip_l), .clip_rght(clip_r), .vol_cur(vol_cur)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_pots(input logic [PW-1:0] g);
        for (int i = 0; i < NB; i++) pot_band[i*PW +: PW] = g;
    endtask

    task automatic send;
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
    endtask

    task automatic pulse_clr;
        clr_clip = 1'b1;
        tick();
        clr_clip = 1'b0;
    endtask

    // Called right after send; lat is the cycle count from in_vld to out_vld.
    task automatic wait_out(output int lat);
        lat = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            lat++;
            if (out_vld) return;
        end
        lat = 99;
    endtask

    task automatic settle;
        pot_vol = 12'd4095;
        set_pots(12'd2048);
        band_lft = '0;
        band_rght = '0;
        in_vld = 1'b1;
        repeat (NSETTLE) tick();
        in_vld = 1'b0;
        repeat (5) tick();
    endtask

    function automatic int vol_model(input int x);
        return (x * 4095) >>> 12;
    endfunction

    // Tests
    task automatic test_reset;
        in_vld = 1'b0; clr_clip = 1'b0; band_lft = '0; band_rght = '0;
        set_pots(12'd2048); pot_vol = 12'd4095;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (aud_l !== 0)   begin failures++; $display("FAIL rst_aud_l got %0d exp 0", aud_l); end
        checks++; if (aud_r !== 0)   begin failures++; $display("FAIL rst_aud_r got %0d exp 0", aud_r); end
        checks++; if (out_vld !== 0) begin failures++; $display("FAIL rst_out_vld got %0d exp 0", out_vld); end
        checks++; if (clip_l !== 0 || clip_r !== 0) begin failures++; $display("FAIL rst_clip got %0d%0d exp 00", clip_l, clip_r); end
        checks++; if (vol_cur !== 0) begin failures++; $display("FAIL rst_vol got %0d exp 0", vol_cur); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_unity;
        int lat;
        settle();
        checks++; if (vol_cur !== 4095) begin failures++; $display("FAIL settle_vol got %0d exp 4095", vol_cur); end
        band_lft[0 +: DW] = 16'sd1000;
        band_rght[0 +: DW] = 16'sd1000;
        send();
        wait_out(lat);
        checks++; if (lat !== 3)    begin failures++; $display("FAIL unity_lat got %0d exp 3", lat); end
        checks++; if (aud_l !== 999) begin failures++; $display("FAIL unity_l got %0d exp 999", aud_l); end
        checks++; if (aud_r !== 999) begin failures++; $display("FAIL unity_r got %0d exp 999", aud_r); end
        checks++; if (clip_l !== 0 || clip_r !== 0) begin failures++; $display("FAIL unity_clip got %0d%0d exp 00", clip_l, clip_r); end
        tick();
        checks++; if (out_vld !== 0) begin failures++; $display("FAIL unity_strobe_width got %0d exp 0", out_vld); end
        checks++; if (aud_l !== 999) begin failures++; $display("FAIL unity_hold got %0d exp 999", aud_l); end
    endtask

    task automatic test_mixed;
        int lat;
        int lv[NB] = '{100, 200, -300, 400, 50};
        int rv[NB] = '{-1, 1, 0, 0, 7};
        int pv[NB] = '{2048, 1024, 4095, 0, 3000};
        for (int i = 0; i < NB; i++) begin
            band_lft[i*DW +: DW]  = DW'(lv[i]);
            band_rght[i*DW +: DW] = DW'(rv[i]);
            pot_band[i*PW +: PW]  = PW'(pv[i]);
        end
        send();
        wait_out(lat);
        checks++; if (lat !== 3)      begin failures++; $display("FAIL mixed_lat got %0d exp 3", lat); end
        checks++; if (aud_l !== -327) begin failures++; $display("FAIL mixed_l got %0d exp -327", aud_l); end
        checks++; if (aud_r !== 8)    begin failures++; $display("FAIL mixed_r got %0d exp 8", aud_r); end
        set_pots(12'd2048);
    endtask

    task automatic test_sum_sat;
        int lat;
        pulse_clr();
        for (int i = 0; i < NB; i++) begin
            band_lft[i*DW +: DW] = 16'sd20000;
            band_rght[i*DW +: DW] = 16'sd20000;
        end
        send();
        wait_out(lat);
        checks++; if (lat !== 3)        begin failures++; $display("FAIL sumsat_lat got %0d exp 3", lat); end
        checks++; if (aud_l !== 32759)  begin failures++; $display("FAIL sumsat_l got %0d exp 32759", aud_l); end
        checks++; if (aud_r !== 32759)  begin failures++; $display("FAIL sumsat_r got %0d exp 32759", aud_r); end
        checks++; if (clip_l !== 1 || clip_r !== 1) begin failures++; $display("FAIL sumsat_clip got %0d%0d exp 11", clip_l, clip_r); end
        band_lft = '0; band_rght = '0;
        band_lft[0 +: DW] = 16'sd1000;
        send();
        wait_out(lat);
        checks++; if (aud_l !== 999)    begin failures++; $display("FAIL sticky_l got %0d exp 999", aud_l); end
        checks++; if (clip_l !== 1 || clip_r !== 1) begin failures++; $display("FAIL sticky_clip got %0d%0d exp 11", clip_l, clip_r); end
        pulse_clr();
        checks++; if (clip_l !== 0 || clip_r !== 0) begin failures++; $display("FAIL clr_clip got %0d%0d exp 00", clip_l, clip_r); end
        // Left-only saturation whose flag set lands on the same edge as a clear.
        band_rght = '0;
        for (int i = 0; i < NB; i++) band_lft[i*DW +: DW] = 16'sd20000;
        send();
        clr_clip = 1'b1;
        tick();
        clr_clip = 1'b0;
        checks++; if (clip_l !== 1) begin failures++; $display("FAIL set_wins_l got %0d exp 1", clip_l); end
        checks++; if (clip_r !== 0) begin failures++; $display("FAIL set_wins_r got %0d exp 0", clip_r); end
        repeat (3) tick();
        pulse_clr();
    endtask

    task automatic test_band_sat;
        int lat;
        band_lft = '0; band_rght = '0;
        band_lft[0 +: DW]  = 16'h8000;
        band_rght[0 +: DW] = 16'h7fff;
        pot_band[0 +: PW]  = 12'd4095;
        send();
        checks++; if (clip_l !== 1 || clip_r !== 1) begin failures++; $display("FAIL bandsat_early_clip got %0d%0d exp 11", clip_l, clip_r); end
        wait_out(lat);
        checks++; if (lat !== 3)        begin failures++; $display("FAIL bandsat_lat got %0d exp 3", lat); end
        checks++; if (aud_l !== -32760) begin failures++; $display("FAIL bandsat_l got %0d exp -32760", aud_l); end
        checks++; if (aud_r !== 32759)  begin failures++; $display("FAIL bandsat_r got %0d exp 32759", aud_r); end
        set_pots(12'd2048);
        pulse_clr();
    endtask

    task automatic test_ramp;
        int lat;
        int ramp_tbl[7] = '{32, 48, 64, 80, 96, 100, 100};
        int e;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        checks++; if (vol_cur !== 0) begin failures++; $display("FAIL ramp_start got %0d exp 0", vol_cur); end
        pot_vol = 12'd100;
        band_lft = '0; band_rght = '0;
        band_lft[0 +: DW]  = 16'sd16384;
        band_rght[0 +: DW] = -16'sd16384;
        send();
        e = RAMP ? 16 : 100;
        checks++; if (vol_cur !== e) begin failures++; $display("FAIL ramp_first got %0d exp %0d", vol_cur, e); end
        wait_out(lat);
        e = RAMP ? 64 : 400;
        checks++; if (aud_l !== e)  begin failures++; $display("FAIL ramp_out_l got %0d exp %0d", aud_l, e); end
        checks++; if (aud_r !== -e) begin failures++; $display("FAIL ramp_out_r got %0d exp %0d", aud_r, -e); end
        band_lft = '0; band_rght = '0;
        in_vld = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            e = RAMP ? ramp_tbl[i] : 100;
            checks++; if (vol_cur !== e) begin failures++; $display("FAIL ramp_step%0d got %0d exp %0d", i, vol_cur, e); end
        end
        in_vld = 1'b0;
        pot_vol = 12'd4000;
        repeat (5) tick();
        checks++; if (vol_cur !== 100) begin failures++; $display("FAIL ramp_idle got %0d exp 100", vol_cur); end
        repeat (4) tick();
    endtask

    task automatic test_back_to_back;
        int n = 0;
        int last = 0;
        settle();
        exp_l_q.delete();
        exp_r_q.delete();
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    int v;
                    if (i >= 8) begin
                        in_vld = 1'b0;
                        repeat (2) tick();
                    end
                    v = i * 2711 - 15000;
                    band_lft[0 +: DW]  = DW'(v);
                    band_rght[0 +: DW] = DW'(-v - 1);
                    exp_l_q.push_back(DW'(vol_model(v)));
                    exp_r_q.push_back(DW'(vol_model(-v - 1)));
                    in_vld = 1'b1;
                    tick();
                end
                in_vld = 1'b0;
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    tick();
                    if (out_vld) begin
                        if (exp_l_q.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL b2b_extra_strobe got strobe at cycle %0d exp none", c);
                        end else begin
                            logic signed [DW-1:0] el, er;
                            el = exp_l_q.pop_front();
                            er = exp_r_q.pop_front();
                            checks++; if (aud_l !== el) begin failures++; $display("FAIL b2b_l%0d got %0d exp %0d", n, aud_l, el); end
                            checks++; if (aud_r !== er) begin failures++; $display("FAIL b2b_r%0d got %0d exp %0d", n, aud_r, er); end
                        end
                        if (n > 0) begin
                            checks++;
                            if ((c - last) !== ((n < 8) ? 1 : 3)) begin
                                failures++;
                                $display("FAIL b2b_gap%0d got %0d exp %0d", n, c - last, (n < 8) ? 1 : 3);
                            end
                        end
                        last = c;
                        n++;
                    end
                end
            end
        join
        checks++; if (n !== 12) begin failures++; $display("FAIL b2b_count got %0d exp 12", n); end
    endtask

    task automatic test_reset_mid;
        int lat;
        int cnt = 0;
        int e;
        band_lft = '0; band_rght = '0;
        band_lft[0 +: DW] = 16'sd5000;
        in_vld = 1'b1;
        repeat (2) tick();
        in_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (out_vld !== 0) begin failures++; $display("FAIL midrst_vld got %0d exp 0", out_vld); end
        checks++; if (aud_l !== 0 || aud_r !== 0) begin failures++; $display("FAIL midrst_aud got %0d/%0d exp 0/0", aud_l, aud_r); end
        checks++; if (vol_cur !== 0) begin failures++; $display("FAIL midrst_vol got %0d exp 0", vol_cur); end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_vld) cnt++;
        end
        checks++; if (cnt !== 0) begin failures++; $display("FAIL midrst_ghost got %0d exp 0", cnt); end
        band_lft[0 +: DW]  = 16'sd4096;
        band_rght[0 +: DW] = -16'sd4096;
        send();
        wait_out(lat);
        e = RAMP ? 16 : 4095;
        checks++; if (lat !== 3)    begin failures++; $display("FAIL midrst_lat got %0d exp 3", lat); end
        checks++; if (aud_l !== e)  begin failures++; $display("FAIL midrst_l got %0d exp %0d", aud_l, e); end
        checks++; if (aud_r !== -e) begin failures++; $display("FAIL midrst_r got %0d exp %0d", aud_r, -e); end
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_unity();
        test_mixed();
        test_sum_sat();
        test_band_sat();
        test_ramp();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
